// File: rtl/sauria_cfg_arbiter_if.sv
// sauria_cfg_arbiter_if: requester and target bus bundle for the SAURIA config arbiter.
//   master modport: arbiter view (drives o_*, receives i_*).
//   slave modport : requester/target environment view.
interface sauria_cfg_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]                   i_req_valid;
    logic [1:0]                   o_req_ready;
    logic [1:0][31:0]             i_req_addr;
    logic [1:0]                   i_req_wren;
    logic [1:0][DATA_W-1:0]       i_req_wdata;
    logic [1:0][DATA_W/8-1:0]     i_req_wstrb;
    logic [1:0]                   o_rsp_valid;
    logic [DATA_W-1:0]            o_rsp_rdata;
    logic                         o_rsp_err;
    logic [2:0]                   o_tgt_valid;
    logic [2:0]                   i_tgt_ready;
    logic [31:0]                  o_tgt_addr;
    logic [2:0]                   o_tgt_region;
    logic                         o_tgt_wren;
    logic [DATA_W-1:0]            o_tgt_wdata;
    logic [DATA_W/8-1:0]          o_tgt_wstrb;
    logic [2:0]                   i_tgt_rsp_valid;
    logic [2:0][DATA_W-1:0]       i_tgt_rdata;
    logic [2:0]                   i_tgt_err;
    logic                         o_busy;
    logic [7:0]                   o_err_cnt;

    modport master (
        input  i_req_valid, i_req_addr, i_req_wren, i_req_wdata, i_req_wstrb,
        input  i_tgt_ready, i_tgt_rsp_valid, i_tgt_rdata, i_tgt_err,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_tgt_valid, o_tgt_addr, o_tgt_region, o_tgt_wren, o_tgt_wdata, o_tgt_wstrb,
        output o_busy, o_err_cnt
    );

    modport slave (
        output i_req_valid, i_req_addr, i_req_wren, i_req_wdata, i_req_wstrb,
        output i_tgt_ready, i_tgt_rsp_valid, i_tgt_rdata, i_tgt_err,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_tgt_valid, o_tgt_addr, o_tgt_region, o_tgt_wren, o_tgt_wdata, o_tgt_wstrb,
        input  o_busy, o_err_cnt
    );
endinterface

// File: rtl/sauria_cfg_arbiter.sv
// sauria_cfg_arbiter: two-requester, single-outstanding arbiter and address decoder for the SAURIA config bus.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : requester handshake/response, target command/response, busy and error count
module sauria_cfg_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic i_clk,
    input logic i_rst,
    sauria_cfg_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                last_q, last_d, g_q, g_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [2:0]          region_q, region_d;
    logic [31:0]         addr_q, addr_d;
    logic                wren_q, wren_d, err_q, err_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic        win, hit, sub_ok, dec_err, tmo;
    logic [1:0]  grant, dec_tgt;
    logic [2:0]  dec_region;
    logic [31:0] a;
    logic [11:0] hi;
    logic [3:0]  mem, rg;

    // Last-granted requester loses a tie.
    assign win   = &bus.i_req_valid ? ~last_q : bus.i_req_valid[1];
    assign grant = (state_q == S_IDLE && !i_rst && |bus.i_req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign a          = bus.i_req_addr[win];
    assign hi         = a[31:20];
    assign mem        = a[19:16];
    assign rg         = a[11:8];
    assign hit        = hi == 12'h441 || hi == 12'h442 || hi == 12'h443;
    assign dec_tgt    = hit ? hi[1:0] - 2'd1 : 2'd0;
    assign sub_ok     = (mem >= 4'd1 && mem <= 4'd3) || (mem == 4'd0 && a[15:12] == 4'd0 && rg <= 4'd9);
    assign dec_region = dec_tgt != 2'd1 ? 3'd0 : mem != 4'd0 ? {1'b1, mem[1:0]} : rg[3:1];
    assign dec_err    = !hit || (dec_tgt == 2'd1 && !sub_ok);
    assign tmo        = TIMEOUT != 0 && cnt_q == 16'(TIMEOUT);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        g_d       = g_q;
        tgt_d     = tgt_q;
        region_d  = region_q;
        addr_d    = addr_q;
        wren_d    = wren_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        err_cnt_d = err_cnt_q;
        cnt_d     = (state_q == S_ISSUE || state_q == S_WAIT) ? cnt_q + 16'd1 : 16'd0;
        case (state_q)
            S_IDLE: if (|grant) begin
                g_d      = win;
                tgt_d    = dec_tgt;
                region_d = dec_region;
                addr_d   = {12'h000, a[19:0]};
                wren_d   = bus.i_req_wren[win];
                wdata_d  = bus.i_req_wdata[win];
                wstrb_d  = bus.i_req_wstrb[win];
                err_d    = dec_err;
                rdata_d  = '0;
                state_d  = dec_err ? S_RESP : S_ISSUE;
            end
            S_ISSUE: if (tmo) begin
                err_d   = 1'b1;
                state_d = S_RESP;
            end else if (bus.i_tgt_ready[tgt_q]) begin
                state_d = S_WAIT;
            end
            // A response in the timeout cycle takes precedence over the timeout.
            S_WAIT: if (bus.i_tgt_rsp_valid[tgt_q]) begin
                err_d   = bus.i_tgt_err[tgt_q];
                rdata_d = (wren_q || bus.i_tgt_err[tgt_q]) ? '0 : bus.i_tgt_rdata[tgt_q];
                state_d = S_RESP;
            end else if (tmo) begin
                err_d   = 1'b1;
                state_d = S_RESP;
            end
            default: begin
                last_d    = g_q;
                err_cnt_d = (err_q && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            g_q       <= 1'b0;
            tgt_q     <= 2'd0;
            region_q  <= 3'd0;
            addr_q    <= '0;
            wren_q    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            g_q       <= g_d;
            tgt_q     <= tgt_d;
            region_q  <= region_d;
            addr_q    <= addr_d;
            wren_q    <= wren_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o_req_ready  = grant;
    assign bus.o_tgt_valid  = state_q == S_ISSUE ? 3'b001 << tgt_q : 3'b000;
    assign bus.o_rsp_valid  = state_q == S_RESP ? 2'b01 << g_q : 2'b00;
    assign bus.o_rsp_rdata  = state_q == S_RESP ? rdata_q : '0;
    assign bus.o_rsp_err    = state_q == S_RESP && err_q;
    assign bus.o_tgt_addr   = addr_q;
    assign bus.o_tgt_region = region_q;
    assign bus.o_tgt_wren   = wren_q;
    assign bus.o_tgt_wdata  = wdata_q;
    assign bus.o_tgt_wstrb  = wstrb_q;
    assign bus.o_busy       = state_q != S_IDLE;
    assign bus.o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_sauria_cfg_arbiter.sv
// tb_sauria_cfg_arbiter: directed self-checking bench for sauria_cfg_arbiter (TIMEOUT=4).
module tb_sauria_cfg_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    sauria_cfg_arbiter_if #(.DATA_W(32)) bus ();

    sauria_cfg_arbiter #(.DATA_W(32), .TIMEOUT(4)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and acts as an immediate-ready target that responds one cycle after
    // the command is seen; returns observations, leaves the bench in the following IDLE cycle.
    task automatic do_txn(input int r, input logic [31:0] a, input logic w, output int lat,
                          output logic [2:0] tv, output logic [2:0] rg, output logic e,
                          output logic [31:0] rd);
        logic [2:0] prev;
        int k;
        lat = -1; tv = 0; rg = 0; e = 0; rd = 0; prev = 0; k = 0;
        bus.i_tgt_ready = 3'b111;
        bus.i_req_valid[r] = 1'b1;
        bus.i_req_addr[r] = a;
        bus.i_req_wren[r] = w;
        bus.i_req_wdata[r] = 32'h1234_5678;
        bus.i_req_wstrb[r] = 4'hF;
        #1;
        while (bus.o_req_ready[r] !== 1'b1 && k < 20) begin
            tick();
            #1;
            k++;
        end
        tick();
        bus.i_req_valid[r] = 1'b0;
        if (k < 20) begin
            for (int c = 1; c <= 20; c++) begin
                bus.i_tgt_rsp_valid = prev;
                #1;
                if (bus.o_tgt_valid != 0) begin
                    tv = bus.o_tgt_valid;
                    rg = bus.o_tgt_region;
                end
                prev = bus.o_tgt_valid;
                if (bus.o_rsp_valid[r]) begin
                    lat = c;
                    e = bus.o_rsp_err;
                    rd = bus.o_rsp_rdata;
                    break;
                end
                tick();
            end
        end
        bus.i_tgt_rsp_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset();
        bus.i_req_valid = 2'b11;
        tick();
        #1;
        n_assert++; if (bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", bus.o_req_ready); end
        n_assert++; if (bus.o_tgt_valid !== 3'b000) begin n_fail++; $display("FAIL reset_tgt_valid got %b want 000", bus.o_tgt_valid); end
        n_assert++; if (bus.o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 00", bus.o_rsp_valid); end
        n_assert++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        n_assert++; if (bus.o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", bus.o_err_cnt); end
        n_assert++; if (bus.o_tgt_addr !== 32'd0) begin n_fail++; $display("FAIL reset_tgt_addr got %h want 0", bus.o_tgt_addr); end
        bus.i_req_valid = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int g[4];
        int n;
        logic both;
        logic [2:0] prev;
        n = 0; both = 0; prev = 0;
        bus.i_req_addr[0] = 32'h4410_0000;
        bus.i_req_addr[1] = 32'h4430_0000;
        bus.i_req_wren = 2'b00;
        bus.i_tgt_ready = 3'b111;
        bus.i_req_valid = 2'b11;
        for (int c = 0; c < 60 && n < 4; c++) begin
            bus.i_tgt_rsp_valid = prev;
            #1;
            if (bus.o_req_ready == 2'b11) both = 1;
            if (bus.o_req_ready != 2'b00) begin
                g[n] = int'(bus.o_req_ready[1]);
                n++;
            end
            prev = bus.o_tgt_valid;
            tick();
        end
        bus.i_req_valid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            bus.i_tgt_rsp_valid = prev;
            #1;
            prev = bus.o_tgt_valid;
            tick();
        end
        bus.i_tgt_rsp_valid = 3'b000;
        n_assert++; if (n !== 4) begin n_fail++; $display("FAIL rr_count got %0d want 4", n); end
        n_assert++; if (both !== 1'b0) begin n_fail++; $display("FAIL rr_both_ready got %b want 0", both); end
        for (int i = 0; i < n; i++) begin
            n_assert++; if (g[i] !== i % 2) begin n_fail++; $display("FAIL rr_grant%0d got %0d want %0d", i, g[i], i % 2); end
        end
    endtask

    task automatic test_read();
        bus.i_tgt_ready = 3'b111;
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_addr[0] = 32'h4420_0404;
        bus.i_req_wren[0] = 1'b0;
        #1;
        n_assert++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL read_ready got %b want 01", bus.o_req_ready); end
        tick();
        bus.i_req_valid[0] = 1'b0;
        #1;
        n_assert++; if (bus.o_tgt_valid !== 3'b010) begin n_fail++; $display("FAIL read_tgt_valid got %b want 010", bus.o_tgt_valid); end
        n_assert++; if (bus.o_tgt_addr !== 32'h0000_0404) begin n_fail++; $display("FAIL read_tgt_addr got %h want 00000404", bus.o_tgt_addr); end
        n_assert++; if (bus.o_tgt_region !== 3'd2) begin n_fail++; $display("FAIL read_region got %0d want 2", bus.o_tgt_region); end
        n_assert++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL read_busy got %b want 1", bus.o_busy); end
        tick();
        tick();
        tick();
        bus.i_tgt_rsp_valid = 3'b010;
        bus.i_tgt_rdata[1] = 32'hCAFE_F00D;
        bus.i_tgt_err = 3'b000;
        #1;
        n_assert++; if (bus.o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL read_early_rsp got %b want 00", bus.o_rsp_valid); end
        tick();
        bus.i_tgt_rsp_valid = 3'b000;
        #1;
        n_assert++; if (bus.o_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL read_rsp_valid got %b want 01", bus.o_rsp_valid); end
        n_assert++; if (bus.o_rsp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_rdata got %h want cafef00d", bus.o_rsp_rdata); end
        n_assert++; if (bus.o_rsp_err !== 1'b0) begin n_fail++; $display("FAIL read_err got %b want 0", bus.o_rsp_err); end
        tick();
    endtask

    task automatic test_decode_err();
        logic [31:0] addrs[3];
        int lat;
        logic [2:0] tv, rg;
        logic e;
        logic [31:0] rd;
        addrs = '{32'h4450_0000, 32'h4420_0A00, 32'h4424_0000};
        for (int i = 0; i < 3; i++) begin
            do_txn(0, addrs[i], 1'b0, lat, tv, rg, e, rd);
            n_assert++; if (lat !== 1) begin n_fail++; $display("FAIL dec%0d_latency got %0d want 1", i, lat); end
            n_assert++; if (e !== 1'b1) begin n_fail++; $display("FAIL dec%0d_err got %b want 1", i, e); end
            n_assert++; if (rd !== 32'd0) begin n_fail++; $display("FAIL dec%0d_rdata got %h want 0", i, rd); end
            n_assert++; if (tv !== 3'b000) begin n_fail++; $display("FAIL dec%0d_tgt_valid got %b want 000", i, tv); end
        end
        n_assert++; if (bus.o_err_cnt !== 8'd3) begin n_fail++; $display("FAIL dec_err_cnt got %0d want 3", bus.o_err_cnt); end
    endtask

    task automatic test_region_sweep();
        logic [31:0] addrs[8];
        int lat;
        logic [2:0] tv, rg;
        logic e;
        logic [31:0] rd;
        addrs = '{32'h4420_0000, 32'h4420_0200, 32'h4420_0400, 32'h4420_0600,
                  32'h4420_0800, 32'h4421_0000, 32'h4422_0000, 32'h4423_0000};
        bus.i_tgt_rdata[1] = 32'h5A5A_0001;
        bus.i_tgt_err = 3'b000;
        for (int i = 0; i < 8; i++) begin
            do_txn(1, addrs[i], 1'b0, lat, tv, rg, e, rd);
            n_assert++; if (rg !== 3'(i)) begin n_fail++; $display("FAIL sweep%0d_region got %0d want %0d", i, rg, i); end
            n_assert++; if (lat !== 3) begin n_fail++; $display("FAIL sweep%0d_latency got %0d want 3", i, lat); end
            n_assert++; if (tv !== 3'b010) begin n_fail++; $display("FAIL sweep%0d_tgt_valid got %b want 010", i, tv); end
            n_assert++; if (rd !== 32'h5A5A_0001) begin n_fail++; $display("FAIL sweep%0d_rdata got %h want 5a5a0001", i, rd); end
        end
    endtask

    task automatic test_timeout();
        int hi_cnt;
        logic early;
        hi_cnt = 0; early = 0;
        bus.i_tgt_ready = 3'b000;
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_addr[0] = 32'h4430_0010;
        bus.i_req_wren[0] = 1'b1;
        bus.i_req_wdata[0] = 32'hDEAD_BEEF;
        #1;
        n_assert++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL tmo_ready got %b want 01", bus.o_req_ready); end
        tick();
        bus.i_req_valid[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (c <= 4 && bus.o_tgt_valid == 3'b100) hi_cnt++;
            if (bus.o_rsp_valid != 2'b00) early = 1;
            if (c == 1) begin
                n_assert++; if (bus.o_tgt_addr !== 32'h0000_0010 || bus.o_tgt_wren !== 1'b1) begin n_fail++; $display("FAIL tmo_cmd got addr %h wren %b want 00000010/1", bus.o_tgt_addr, bus.o_tgt_wren); end
            end
            tick();
        end
        n_assert++; if (hi_cnt !== 4) begin n_fail++; $display("FAIL tmo_valid_cycles got %0d want 4", hi_cnt); end
        n_assert++; if (early !== 1'b0) begin n_fail++; $display("FAIL tmo_early_rsp got %b want 0", early); end
        #1;
        n_assert++; if (bus.o_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL tmo_rsp_valid got %b want 01", bus.o_rsp_valid); end
        n_assert++; if (bus.o_rsp_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", bus.o_rsp_err); end
        n_assert++; if (bus.o_tgt_valid !== 3'b000) begin n_fail++; $display("FAIL tmo_tgt_drop got %b want 000", bus.o_tgt_valid); end
        bus.i_tgt_rsp_valid = 3'b100;
        tick();
        #1;
        n_assert++; if (bus.o_rsp_valid !== 2'b00 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_late_rsp got rsp %b busy %b want 00/0", bus.o_rsp_valid, bus.o_busy); end
        tick();
        bus.i_tgt_rsp_valid = 3'b000;
        #1;
        n_assert++; if (bus.o_err_cnt !== 8'd4) begin n_fail++; $display("FAIL tmo_err_cnt got %0d want 4", bus.o_err_cnt); end
        n_assert++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_late_busy got %b want 0", bus.o_busy); end
        bus.i_req_wren[0] = 1'b0;
    endtask

    task automatic test_rsp_at_timeout();
        bus.i_tgt_ready = 3'b111;
        bus.i_tgt_rdata[2] = 32'h0000_0055;
        bus.i_tgt_err = 3'b000;
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_addr[0] = 32'h4430_0000;
        bus.i_req_wren[0] = 1'b0;
        #1;
        n_assert++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL race_ready got %b want 01", bus.o_req_ready); end
        tick();
        bus.i_req_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        bus.i_tgt_rsp_valid = 3'b100;
        #1;
        n_assert++; if (bus.o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL race_early_rsp got %b want 00", bus.o_rsp_valid); end
        tick();
        bus.i_tgt_rsp_valid = 3'b000;
        #1;
        n_assert++; if (bus.o_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL race_rsp_valid got %b want 01", bus.o_rsp_valid); end
        n_assert++; if (bus.o_rsp_err !== 1'b0) begin n_fail++; $display("FAIL race_err got %b want 0", bus.o_rsp_err); end
        n_assert++; if (bus.o_rsp_rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL race_rdata got %h want 00000055", bus.o_rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 0;
        bus.i_tgt_ready = 3'b111;
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_addr[0] = 32'h4410_0000;
        bus.i_req_wren[0] = 1'b0;
        #1;
        tick();
        bus.i_req_valid[0] = 1'b0;
        #1;
        n_assert++; if (bus.o_tgt_valid !== 3'b001) begin n_fail++; $display("FAIL mid_tgt_valid got %b want 001", bus.o_tgt_valid); end
        tick();
        tick();
        n_assert++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", bus.o_busy); end
        rst = 1'b1;
        #1;
        n_assert++; if (bus.o_busy !== 1'b0 || bus.o_tgt_valid !== 3'b000 || bus.o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_async got busy %b tgt %b rsp %b want 0/000/00", bus.o_busy, bus.o_tgt_valid, bus.o_rsp_valid); end
        n_assert++; if (bus.o_err_cnt !== 8'd0 || bus.o_tgt_addr !== 32'd0) begin n_fail++; $display("FAIL mid_regs got err_cnt %0d addr %h want 0/0", bus.o_err_cnt, bus.o_tgt_addr); end
        bus.i_req_valid = 2'b11;
        #1;
        n_assert++; if (bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_ready_in_reset got %b want 00", bus.o_req_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.o_rsp_valid != 2'b00) seen = 1;
        end
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp got %b want 0", seen); end
        rst = 1'b0;
        #1;
        n_assert++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_tie_after got %b want 01", bus.o_req_ready); end
        bus.i_req_valid = 2'b00;
        tick();
        #1;
        n_assert++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL drop_valid_busy got %b want 0", bus.o_busy); end
    endtask

    initial begin
        bus.i_req_valid = '0;
        bus.i_req_addr = '0;
        bus.i_req_wren = '0;
        bus.i_req_wdata = '0;
        bus.i_req_wstrb = '0;
        bus.i_tgt_ready = '0;
        bus.i_tgt_rsp_valid = '0;
        bus.i_tgt_rdata = '0;
        bus.i_tgt_err = '0;
        test_reset();
        test_round_robin();
        test_read();
        test_decode_err();
        test_region_sweep();
        test_timeout();
        test_rsp_at_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
